booth_mult_seq: RTL

Iterative radix-2 Booth multiplier datapath and sequencer for the EX-stage multiply path. It holds the A/Q/Q_-1 working registers and presents {Q[0], Q_-1} to a recode stage. It consumes the resulting 2-bit Booth op (00 none, 01 add M, 10 subtract M), then arithmetic-shifts once per cycle. It delivers a signed 2*WIDTH product with a done pulse to the pipeline stall logic.

---
 rtl/mult_pkg.sv | 14 +
 rtl/booth_recode.sv | 19 +
 rtl/booth_mult_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and Booth operation codes for the sequential multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

endpackage

// File: rtl/booth_recode.sv
// Radix-2 Booth recoder: maps {Q[0], Q_-1} onto an add/subtract/none operation.
module booth_recode
    import mult_pkg::*;
(
    input  logic       q1,
    input  logic       q0,
    output logic [1:0] op
);

    always_comb begin
        op = OP_NONE;
        case ({q1, q0})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NONE;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier: one add/sub plus arithmetic shift per cycle,
// signed 2*WIDTH product delivered with a one-cycle done pulse.
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic signed [WIDTH-1:0]     multiplicand,
    input  logic signed [WIDTH-1:0]     multiplier,
    output logic                        busy,
    output logic                        done,
    output logic signed [2*WIDTH-1:0]   product
);

    state_t                   state;
    state_t                   state_nxt;
    logic signed [WIDTH:0]    a;
    logic signed [WIDTH:0]    m;
    logic [WIDTH-1:0]         q;
    logic                     q_m1;
    logic [CNT_W-1:0]         count;
    logic [1:0]               op;
    logic signed [WIDTH:0]    sum;
    logic signed [WIDTH:0]    a_sh;
    logic [WIDTH-1:0]         q_sh;
    logic                     last;

    booth_recode u_recode (
        .q1 (q[0]),
        .q0 (q_m1),
        .op (op)
    );

    // A is one bit wider than the operands, so A - M never overflows for M = -2^(WIDTH-1)
    always_comb begin
        sum = a;
        case (op)
            OP_ADD:  sum = a + m;
            OP_SUB:  sum = a - m;
            default: sum = a;
        endcase
        a_sh = {sum[WIDTH], sum[WIDTH:1]};
        q_sh = {sum[0], q[WIDTH-1:1]};
    end

    assign last = (count == CNT_W'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a       <= '0;
            m       <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a     <= '0;
                        m     <= {multiplicand[WIDTH-1], multiplicand};
                        q     <= multiplier;
                        q_m1  <= 1'b0;
                        count <= CNT_W'(WIDTH);
                    end
                end
                RUN: begin
                    a     <= a_sh;
                    q     <= q_sh;
                    q_m1  <= q[0];
                    count <= count - CNT_W'(1);
                    if (last) begin
                        product <= {a_sh[WIDTH-1:0], q_sh};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
